// File: rtl/jumppred_btb.sv
// jumppred_btb: direct-mapped branch target buffer with per-entry saturating
// direction counters. A lookup captured on one edge is presented to decode as
// a registered prediction; resolved jumps update or allocate entries, and a
// saturating counter tallies mispredicts.
module jumppred_btb #(
    parameter int PC_W    = 16,
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 2,
    parameter int STAT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              lookup_en,
    input  logic [PC_W-1:0]   lookup_pc,
    input  logic              update_en,
    input  logic [PC_W-1:0]   update_pc,
    input  logic              update_taken,
    input  logic              update_uncond,
    input  logic [PC_W-1:0]   update_target,
    input  logic              update_mispredict,
    input  logic              clear,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [PC_W-1:0]   pred_target,
    output logic [STAT_W-1:0] miss_count
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - IDX_W;

    // Strongly taken is all ones; weakly taken is the MSB alone.
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_WEAK = CNT_MAX ^ (CNT_MAX >> 1);
    localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

    // Counter step up, holding at the strongly-taken ceiling.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        logic [CNT_W-1:0] r;
        if (c == CNT_MAX) begin
            r = c;
        end else begin
            r = c + CNT_W'(1);
        end
        return r;
    endfunction

    // Counter step down, holding at the strongly-not-taken floor.
    function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] c);
        logic [CNT_W-1:0] r;
        if (c == {CNT_W{1'b0}}) begin
            r = c;
        end else begin
            r = c - CNT_W'(1);
        end
        return r;
    endfunction

    // Entry storage; only the valid bits need a defined reset value.
    logic [ENTRIES-1:0] valid_r;
    logic [TAG_W-1:0]   tag_r    [ENTRIES];
    logic [PC_W-1:0]    target_r [ENTRIES];
    logic [CNT_W-1:0]   cnt_r    [ENTRIES];

    logic [IDX_W-1:0] upd_idx_s;
    logic [TAG_W-1:0] upd_tag_s;
    logic             upd_hit_s;
    logic             upd_write_s;
    logic [PC_W-1:0]  upd_target_s;
    logic [CNT_W-1:0] upd_cnt_s;

    logic [IDX_W-1:0] lk_idx_s;
    logic [TAG_W-1:0] lk_tag_s;
    logic             lk_valid_s;
    logic [TAG_W-1:0] lk_entry_tag_s;
    logic [PC_W-1:0]  lk_entry_target_s;
    logic [CNT_W-1:0] lk_entry_cnt_s;
    logic             lk_hit_s;

    logic             pred_hit_r;
    logic             pred_taken_r;
    logic [PC_W-1:0]  pred_target_r;
    logic [STAT_W-1:0] miss_count_r;

    assign upd_idx_s = update_pc[IDX_W-1:0];
    assign upd_tag_s = update_pc[PC_W-1:IDX_W];
    assign upd_hit_s = valid_r[upd_idx_s] && (tag_r[upd_idx_s] == upd_tag_s);

    assign lk_idx_s  = lookup_pc[IDX_W-1:0];
    assign lk_tag_s  = lookup_pc[PC_W-1:IDX_W];

    // Next contents of the updated slot; clear suppresses any write.
    always_comb begin
        upd_write_s  = 1'b0;
        upd_target_s = target_r[upd_idx_s];
        upd_cnt_s    = cnt_r[upd_idx_s];
        if (update_en && !clear) begin
            if (upd_hit_s) begin
                upd_write_s = 1'b1;
                if (update_taken) begin
                    upd_target_s = update_target;
                    if (update_uncond) begin
                        upd_cnt_s = CNT_MAX;
                    end else begin
                        upd_cnt_s = sat_inc(cnt_r[upd_idx_s]);
                    end
                end else begin
                    upd_cnt_s = sat_dec(cnt_r[upd_idx_s]);
                end
            end else if (update_taken) begin
                upd_write_s  = 1'b1;
                upd_target_s = update_target;
                if (update_uncond) begin
                    upd_cnt_s = CNT_MAX;
                end else begin
                    upd_cnt_s = CNT_WEAK;
                end
            end else begin
                upd_write_s = 1'b0;
            end
        end else begin
            upd_write_s = 1'b0;
        end
    end

    // Lookup entry select with write-first bypass from a same-index update.
    always_comb begin
        lk_valid_s        = valid_r[lk_idx_s];
        lk_entry_tag_s    = tag_r[lk_idx_s];
        lk_entry_target_s = target_r[lk_idx_s];
        lk_entry_cnt_s    = cnt_r[lk_idx_s];
        if (upd_write_s && (upd_idx_s == lk_idx_s)) begin
            lk_valid_s        = 1'b1;
            lk_entry_tag_s    = upd_tag_s;
            lk_entry_target_s = upd_target_s;
            lk_entry_cnt_s    = upd_cnt_s;
        end else begin
            lk_valid_s        = valid_r[lk_idx_s];
        end
    end

    assign lk_hit_s = lk_valid_s && (lk_entry_tag_s == lk_tag_s);

    // Valid bits: reset and clear invalidate everything, writes set one slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_r <= '0;
        end else if (clear) begin
            valid_r <= '0;
        end else if (upd_write_s) begin
            valid_r[upd_idx_s] <= 1'b1;
        end else begin
            valid_r <= valid_r;
        end
    end

    // Tag, target and counter payload of the written slot.
    always_ff @(posedge clk) begin
        if (upd_write_s) begin
            tag_r[upd_idx_s]    <= upd_tag_s;
            target_r[upd_idx_s] <= upd_target_s;
            cnt_r[upd_idx_s]    <= upd_cnt_s;
        end
    end

    // Registered prediction: cleared by clear, captured on lookup, else held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pred_hit_r    <= 1'b0;
            pred_taken_r  <= 1'b0;
            pred_target_r <= '0;
        end else if (clear) begin
            pred_hit_r    <= 1'b0;
            pred_taken_r  <= 1'b0;
            pred_target_r <= '0;
        end else if (lookup_en) begin
            pred_hit_r    <= lk_hit_s;
            pred_taken_r  <= lk_hit_s && lk_entry_cnt_s[CNT_W-1];
            pred_target_r <= lk_hit_s ? lk_entry_target_s : {PC_W{1'b0}};
        end else begin
            pred_hit_r    <= pred_hit_r;
            pred_taken_r  <= pred_taken_r;
            pred_target_r <= pred_target_r;
        end
    end

    // Saturating mispredict tally, independent of clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            miss_count_r <= '0;
        end else if (update_en && update_mispredict && (miss_count_r != STAT_MAX)) begin
            miss_count_r <= miss_count_r + STAT_W'(1);
        end else begin
            miss_count_r <= miss_count_r;
        end
    end

    assign pred_hit    = pred_hit_r;
    assign pred_taken  = pred_taken_r;
    assign pred_target = pred_target_r;
    assign miss_count  = miss_count_r;

endmodule

// File: tb/tb_jumppred_btb.sv
// Testbench for jumppred_btb: directed scenarios followed by random traffic,
// all compared against an array-based behavioural model of the predictor.
module tb_jumppred_btb;

    localparam int PC_W  = 16;
    localparam int ENT   = 16;
    localparam int CNT_W = 2;
    localparam int SW    = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;
    localparam int CWEAK = 1 << (CNT_W - 1);
    localparam int SMAX  = (1 << SW) - 1;

    logic            clk;
    logic            reset;
    logic            lookup_en;
    logic [PC_W-1:0] lookup_pc;
    logic            update_en;
    logic [PC_W-1:0] update_pc;
    logic            update_taken;
    logic            update_uncond;
    logic [PC_W-1:0] update_target;
    logic            update_mispredict;
    logic            clear;
    logic            pred_hit;
    logic            pred_taken;
    logic [PC_W-1:0] pred_target;
    logic [SW-1:0]   miss_count;

    int checks;
    int errors;

    // Reference model state
    int m_valid [ENT];
    int m_tag   [ENT];
    int m_tgt   [ENT];
    int m_cnt   [ENT];
    int m_hit, m_taken, m_target, m_miss;

    jumppred_btb #(.PC_W(PC_W), .ENTRIES(ENT), .CNT_W(CNT_W), .STAT_W(SW)) dut (
        .clk(clk), .reset(reset),
        .lookup_en(lookup_en), .lookup_pc(lookup_pc),
        .update_en(update_en), .update_pc(update_pc),
        .update_taken(update_taken), .update_uncond(update_uncond),
        .update_target(update_target), .update_mispredict(update_mispredict),
        .clear(clear),
        .pred_hit(pred_hit), .pred_taken(pred_taken),
        .pred_target(pred_target), .miss_count(miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < ENT; i++) m_valid[i] = 0;
        m_hit = 0; m_taken = 0; m_target = 0; m_miss = 0;
    endtask

    // One clock edge of the predictor's architectural behaviour
    task automatic model_edge();
        int idx, tg;
        if (!reset) begin
            model_reset();
            return;
        end
        if (update_en && update_mispredict && m_miss < SMAX) m_miss++;
        if (clear) begin
            for (int i = 0; i < ENT; i++) m_valid[i] = 0;
            m_hit = 0; m_taken = 0; m_target = 0;
            return;
        end
        if (update_en) begin
            idx = int'(update_pc) % ENT;
            tg  = int'(update_pc) / ENT;
            if (m_valid[idx] != 0 && m_tag[idx] == tg) begin
                if (update_taken) begin
                    m_tgt[idx] = int'(update_target);
                    if (update_uncond) m_cnt[idx] = CMAX;
                    else if (m_cnt[idx] < CMAX) m_cnt[idx] = m_cnt[idx] + 1;
                end else if (m_cnt[idx] > 0) begin
                    m_cnt[idx] = m_cnt[idx] - 1;
                end
            end else if (update_taken) begin
                m_valid[idx] = 1;
                m_tag[idx]   = tg;
                m_tgt[idx]   = int'(update_target);
                m_cnt[idx]   = update_uncond ? CMAX : CWEAK;
            end
        end
        if (lookup_en) begin
            idx = int'(lookup_pc) % ENT;
            tg  = int'(lookup_pc) / ENT;
            m_hit    = (m_valid[idx] != 0 && m_tag[idx] == tg) ? 1 : 0;
            m_taken  = (m_hit != 0 && m_cnt[idx] >= CWEAK) ? 1 : 0;
            m_target = (m_hit != 0) ? m_tgt[idx] : 0;
        end
    endtask

    task automatic compare_all();
        check("hit",    int'(pred_hit),    m_hit);
        check("taken",  int'(pred_taken),  m_taken);
        check("target", int'(pred_target), m_target);
        check("miss",   int'(miss_count),  m_miss);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        model_edge();
        compare_all();
    endtask

    task automatic idle();
        lookup_en = 1'b0; lookup_pc = '0;
        update_en = 1'b0; update_pc = '0; update_taken = 1'b0;
        update_uncond = 1'b0; update_target = '0; update_mispredict = 1'b0;
        clear = 1'b0;
    endtask

    task automatic upd(input logic [PC_W-1:0] pc, input logic tk, input logic un,
                       input logic [PC_W-1:0] tgt, input logic mp);
        update_en = 1'b1; update_pc = pc; update_taken = tk;
        update_uncond = un; update_target = tgt; update_mispredict = mp;
    endtask

    task automatic look(input logic [PC_W-1:0] pc);
        lookup_en = 1'b1; lookup_pc = pc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0;
        errors = 0;
        idle();
        model_reset();
        reset = 1'b0;
        #1;
        check("rst_hit", int'(pred_hit), 0);
        check("rst_miss", int'(miss_count), 0);
        cycle();
        cycle();
        reset = 1'b1;

        // Allocate conditional taken jump, then hit and same-index tag miss
        idle(); upd(16'h0045, 1'b1, 1'b0, 16'h0100, 1'b0); cycle();
        idle(); look(16'h0045); cycle();
        check("alloc_hit", int'(pred_hit), 1);
        check("alloc_taken", int'(pred_taken), 1);
        check("alloc_target", int'(pred_target), 16'h0100);
        idle(); look(16'h0055); cycle();
        check("tagmiss_hit", int'(pred_hit), 0);
        check("tagmiss_target", int'(pred_target), 0);

        // Saturation down then up
        for (int i = 0; i < 3; i++) begin
            idle(); upd(16'h0045, 1'b0, 1'b0, 16'h0000, 1'b0); cycle();
        end
        idle(); look(16'h0045); cycle();
        check("sat0_hit", int'(pred_hit), 1);
        check("sat0_taken", int'(pred_taken), 0);
        check("sat0_target", int'(pred_target), 16'h0100);
        for (int i = 0; i < 3; i++) begin
            idle(); upd(16'h0045, 1'b1, 1'b0, 16'h0100, 1'b0); cycle();
        end
        idle(); look(16'h0045); cycle();
        check("sat3_taken", int'(pred_taken), 1);

        // Bring counter to 2, then same-cycle not-taken update and lookup
        idle(); upd(16'h0045, 1'b0, 1'b0, 16'h0000, 1'b0); cycle();
        idle(); upd(16'h0045, 1'b0, 1'b0, 16'h0000, 1'b0); look(16'h0045); cycle();
        check("bypass_hit", int'(pred_hit), 1);
        check("bypass_taken", int'(pred_taken), 0);
        idle();
        for (int i = 0; i < 3; i++) begin
            lookup_pc = 16'h0033; cycle();
            check("stall_hit", int'(pred_hit), 1);
            check("stall_target", int'(pred_target), 16'h0100);
        end

        // Clear beats update and lookup
        idle(); clear = 1'b1; upd(16'h0033, 1'b1, 1'b0, 16'h0200, 1'b0); look(16'h0045); cycle();
        check("clr_hit", int'(pred_hit), 0);
        check("clr_taken", int'(pred_taken), 0);
        check("clr_target", int'(pred_target), 0);
        idle(); look(16'h0033); cycle();
        check("clr_dropped", int'(pred_hit), 0);

        // Asynchronous reset mid-stream after allocations
        idle(); upd(16'h0045, 1'b1, 1'b1, 16'h0300, 1'b1); cycle();
        idle(); look(16'h0045); cycle();
        check("pre_rst_hit", int'(pred_hit), 1);
        reset = 1'b0;
        #1;
        model_reset();
        check("async_hit", int'(pred_hit), 0);
        check("async_target", int'(pred_target), 0);
        check("async_miss", int'(miss_count), 0);
        cycle();
        reset = 1'b1;
        idle(); look(16'h0040); cycle();
        check("post_rst_hit", int'(pred_hit), 0);
        idle(); look(16'h0045); cycle();
        check("post_rst_inval", int'(pred_hit), 0);

        // Mispredict counter saturation, gating and clear immunity
        for (int i = 0; i < 20; i++) begin
            idle(); upd(16'h0011, 1'b0, 1'b0, 16'h0000, 1'b1); cycle();
        end
        check("miss_sat", int'(miss_count), 15);
        idle(); update_mispredict = 1'b1; cycle();
        check("miss_gated", int'(miss_count), 15);
        idle(); clear = 1'b1; cycle();
        check("miss_clear", int'(miss_count), 15);

        // Release the counter for random traffic
        reset = 1'b0; #1; model_reset(); reset = 1'b1;
        for (int i = 0; i < 400; i++) begin
            idle();
            if ($urandom_range(0, 3) != 0) look(PC_W'($urandom_range(0, 63)));
            if ($urandom_range(0, 1) != 0)
                upd(PC_W'($urandom_range(0, 63)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 3) == 0), PC_W'($urandom_range(0, 65535)),
                    1'($urandom_range(0, 7) == 0));
            else
                update_mispredict = 1'($urandom_range(0, 1));
            clear = 1'($urandom_range(0, 49) == 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
